// File: rtl/axi4_burst_addr_gen.sv
// Per-beat AXI4 burst address generator: one command in, len+1 beats out with per-beat response.
// Optional saturating statistics counters are enabled with `define AXI_BURST_STATS_EN.
module axi4_burst_addr_gen #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 512
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [1:0]            cmd_burst,
    output logic                  beat_valid,
    input  logic                  beat_ready,
    output logic [ADDR_WIDTH-1:0] beat_addr,
    output logic [ADDR_WIDTH-1:0] beat_word,
    output logic [7:0]            beat_idx,
    output logic                  beat_last,
    output logic [1:0]            beat_resp,
    output logic                  beat_en
`ifdef AXI_BURST_STATS_EN
    ,
    output logic [15:0]           stat_bursts,
    output logic [15:0]           stat_err_beats
`endif
);

    localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } axi_burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] nb_q, nb_d;
    logic [ADDR_WIDTH-1:0] lower_q, lower_d;
    logic [ADDR_WIDTH-1:0] wsz_q, wsz_d;
    logic [7:0]            idx_q, idx_d;
    logic [7:0]            len_q, len_d;
    axi_burst_t            burst_q, burst_d;
    logic                  err_q, err_d;

    logic [ADDR_WIDTH-1:0] cmd_nb, cmd_aligned, cmd_wsz, cmd_last_addr;
    logic                  wrap_len_ok, cmd_misaligned, cmd_err;
    logic [ADDR_WIDTH-1:0] incr_next, wrap_sum, next_addr;
    axi_resp_t             resp;

    // Burst-level error check, evaluated on the raw command fields.
    always_comb begin
        cmd_nb         = ADDR_WIDTH'(1) << cmd_size;
        cmd_aligned    = cmd_addr & ~(cmd_nb - ADDR_WIDTH'(1));
        cmd_wsz        = cmd_nb * (ADDR_WIDTH'(cmd_len) + ADDR_WIDTH'(1));
        cmd_last_addr  = cmd_aligned + cmd_nb * ADDR_WIDTH'(cmd_len);
        wrap_len_ok    = (cmd_len == 8'd1) || (cmd_len == 8'd3) ||
                         (cmd_len == 8'd7) || (cmd_len == 8'd15);
        cmd_misaligned = (cmd_addr & (cmd_nb - ADDR_WIDTH'(1))) != '0;
        cmd_err        = (cmd_burst == BURST_RSVD) || (int'(cmd_size) > MAX_SIZE) ||
                         ((cmd_burst == BURST_WRAP) && (!wrap_len_ok || cmd_misaligned)) ||
                         ((cmd_burst == BURST_INCR) && ((cmd_last_addr >> 12) != (cmd_addr >> 12)));
    end

    // Wrap test uses the offset from the window base so it stays correct modulo 2^ADDR_WIDTH.
    always_comb begin
        incr_next = (addr_q & ~(nb_q - ADDR_WIDTH'(1))) + nb_q;
        wrap_sum  = addr_q + nb_q;
        next_addr = incr_next;
        case (burst_q)
            BURST_FIXED: next_addr = addr_q;
            BURST_WRAP:  next_addr = ((wrap_sum - lower_q) >= wsz_q) ? lower_q : wrap_sum;
            default:     next_addr = incr_next;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        nb_d    = nb_q;
        lower_d = lower_q;
        wsz_d   = wsz_q;
        idx_d   = idx_q;
        len_d   = len_q;
        burst_d = burst_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_RUN;
                    addr_d  = cmd_addr;
                    nb_d    = cmd_nb;
                    lower_d = cmd_addr & ~(cmd_wsz - ADDR_WIDTH'(1));
                    wsz_d   = cmd_wsz;
                    idx_d   = 8'd0;
                    len_d   = cmd_len;
                    burst_d = axi_burst_t'(cmd_burst);
                    err_d   = cmd_err;
                end
            end
            S_RUN: begin
                if (beat_ready) begin
                    if (idx_q == len_q) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d  = idx_q + 8'd1;
                        addr_d = next_addr;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            nb_q    <= '0;
            lower_q <= '0;
            wsz_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            burst_q <= BURST_FIXED;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            nb_q    <= nb_d;
            lower_q <= lower_d;
            wsz_q   <= wsz_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            burst_q <= burst_d;
            err_q   <= err_d;
        end
    end

    // Beat outputs are forced to zero whenever no beat is presented.
    always_comb begin
        cmd_ready  = (state_q == S_IDLE);
        beat_valid = (state_q == S_RUN);
        beat_addr  = beat_valid ? addr_q : '0;
        beat_word  = beat_addr >> MAX_SIZE;
        beat_idx   = beat_valid ? idx_q : 8'd0;
        beat_last  = beat_valid && (idx_q == len_q);
        resp       = RESP_OKAY;
        if (beat_valid) begin
            if (err_q)
                resp = RESP_SLVERR;
            else if (32'(beat_word) >= 32'(MEM_DEPTH))
                resp = RESP_DECERR;
        end
        beat_resp = resp;
        beat_en   = beat_valid && (resp == RESP_OKAY);
    end

`ifdef AXI_BURST_STATS_EN
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            stat_bursts    <= '0;
            stat_err_beats <= '0;
        end else begin
            if (cmd_valid && cmd_ready && (stat_bursts != 16'hFFFF))
                stat_bursts <= stat_bursts + 16'd1;
            if (beat_valid && beat_ready && (resp != RESP_OKAY) && (stat_err_beats != 16'hFFFF))
                stat_err_beats <= stat_err_beats + 16'd1;
        end
    end
`endif

endmodule
